// File: rtl/freqcheck_scan_pkg.sv
// rtl/freqcheck_scan_pkg.sv - shared types and default timing constants for the freqcheck scan sequencer
//
// Purpose: FSM state encoding, default gate/settle/timeout lengths and a
//          small constant helper used to size the shared cycle counter.
// Ports:   none (package).
// Options: FREQCHECK_SCAN_OVF_EN (consumed by freqcheck_scan_ctrl only).
package freqcheck_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    GATE,
    WAIT,
    STORE
  } state_t;

  localparam int DEF_GATE_CYCLES    = 1000;
  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/freqcheck_scan_sync.sv
// rtl/freqcheck_scan_sync.sv - per-bit two-flop synchroniser for the asynchronous pulse sources
//
// Purpose: brings each pulse_in bit into the clk domain through two flops.
// Ports:
//   clk  in      system clock
//   rst  in      asynchronous active-low reset (flops clear to 0)
//   i_d  in  W   asynchronous inputs
//   o_q  out W   synchronised outputs (2-cycle latency)
module freqcheck_scan_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/freqcheck_scan_ctrl.sv
// rtl/freqcheck_scan_ctrl.sv - time-shares one freqcheck counter across NUM_CH pulse sources
//
// Purpose: per channel selects the source, waits SETTLE_CYCLES, drives an
//          exact GATE_CYCLES en_count window, collects fc_count (or times
//          out) and publishes a tagged result. Single-scan or continuous.
// Ports:
//   clk          in          system clock
//   rst          in          asynchronous active-low reset
//   start        in          one-cycle request to scan from channel 0
//   continuous   in          wrap to channel 0 after the last channel
//   abort        in          synchronous stop of all activity
//   pulse_in     in  NUM_CH  asynchronous pulse sources
//   pulse_mux    out         synchronised selected source, to freqcheck
//   en_count     out         gate window to freqcheck
//   fc_valid     in          freqcheck result strobe
//   fc_count     in  CNT_W   freqcheck count
//   busy         out         high whenever not idle
//   res_valid    out         one-cycle result strobe
//   res_ch       out CH_W    channel of the result
//   res_count    out CNT_W   measured count (0 on timeout)
//   res_timeout  out         result produced by timeout
//   scan_done    out         strobe alongside the last channel's result
//   res_ovf      out         (FREQCHECK_SCAN_OVF_EN only) count is all-ones
module freqcheck_scan_ctrl
  import freqcheck_scan_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int CH_W          = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [NUM_CH-1:0] pulse_in,
  output logic              pulse_mux,
  output logic              en_count,
  input  logic              fc_valid,
  input  logic [CNT_W-1:0]  fc_count,
  output logic              busy,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_timeout,
  output logic              scan_done
`ifdef FREQCHECK_SCAN_OVF_EN
  ,
  output logic              res_ovf
`endif
);

  // One counter serves settle, gate and timeout phases; it is cleared on
  // every phase entry so it never has to wrap.
  localparam int CNT_BITS =
    $clog2(max_int(max_int(GATE_CYCLES, TIMEOUT_CYCLES), SETTLE_CYCLES) + 1);

  localparam logic [CNT_BITS-1:0] SETTLE_LAST  = CNT_BITS'(SETTLE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] GATE_LAST    = CNT_BITS'(GATE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] TIMEOUT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [CH_W-1:0]     CH_LAST      = CH_W'(NUM_CH - 1);

  state_t              r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CH_W-1:0]     r_ch;
  logic [CNT_W-1:0]    r_lat;
  logic                r_tmo;
  logic                r_busy;
  logic                r_en_count;
  logic                r_res_valid;
  logic [CH_W-1:0]     r_res_ch;
  logic [CNT_W-1:0]    r_res_count;
  logic                r_res_timeout;
  logic                r_scan_done;
  logic [NUM_CH-1:0]   w_sync;

  freqcheck_scan_sync #(
    .W (NUM_CH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pulse_in),
    .o_q (w_sync)
  );

  // The synchroniser's second flop is the register stage; gating with the
  // registered busy flag keeps the output at 0 while idle.
  assign pulse_mux = r_busy & w_sync[r_ch];

`ifdef FREQCHECK_SCAN_OVF_EN
  logic r_res_ovf;
  logic w_ovf_hit;
  assign w_ovf_hit = (r_lat == {CNT_W{1'b1}});
  assign res_ovf   = r_res_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_ovf <= 1'b0;
    end else if (!abort && r_state == STORE) begin
      r_res_ovf <= w_ovf_hit & ~r_tmo;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_ch          <= '0;
      r_lat         <= '0;
      r_tmo         <= 1'b0;
      r_busy        <= 1'b0;
      r_en_count    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_ch      <= '0;
      r_res_count   <= '0;
      r_res_timeout <= 1'b0;
      r_scan_done   <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_scan_done <= 1'b0;
      if (abort) begin
        // Abort outranks start and suppresses any result not yet issued.
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_ch       <= '0;
        r_busy     <= 1'b0;
        r_en_count <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state <= SETTLE;
              r_ch    <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
              r_state    <= GATE;
              r_cnt      <= '0;
              r_en_count <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_BITS'(1);
            end
          end
          GATE: begin
            if (r_cnt == GATE_LAST) begin
              r_state    <= WAIT;
              r_cnt      <= '0;
              r_en_count <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_BITS'(1);
            end
          end
          WAIT: begin
            // A strobe arriving on the final timeout cycle still counts.
            if (fc_valid) begin
              r_state <= STORE;
              r_lat   <= fc_count;
              r_tmo   <= 1'b0;
            end else if (r_cnt == TIMEOUT_LAST) begin
              r_state <= STORE;
              r_lat   <= '0;
              r_tmo   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_BITS'(1);
            end
          end
          STORE: begin
            r_res_valid   <= 1'b1;
            r_res_ch      <= r_ch;
            r_res_count   <= r_lat;
            r_res_timeout <= r_tmo;
            r_cnt         <= '0;
            if (r_ch == CH_LAST) begin
              r_scan_done <= 1'b1;
              r_ch        <= '0;
              if (continuous) begin
                r_state <= SETTLE;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_ch    <= r_ch + CH_W'(1);
              r_state <= SETTLE;
            end
          end
          default: begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_en_count <= 1'b0;
          end
        endcase
      end
    end
  end

  assign en_count    = r_en_count;
  assign busy        = r_busy;
  assign res_valid   = r_res_valid;
  assign res_ch      = r_res_ch;
  assign res_count   = r_res_count;
  assign res_timeout = r_res_timeout;
  assign scan_done   = r_scan_done;

endmodule

// File: tb/tb_freqcheck_scan_ctrl.sv
// tb/tb_freqcheck_scan_ctrl.sv - scoreboard bench for freqcheck_scan_ctrl (optionally FREQCHECK_SCAN_OVF_EN)
module tb_freqcheck_scan_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int GATE   = 1000;
  localparam int SETTLE = 4;
  localparam int TMO    = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic              abort = 1'b0;
  logic [NUM_CH-1:0] pulse_in = '0;
  logic              fc_valid = 1'b0;
  logic [CNT_W-1:0]  fc_count = '0;
  logic              pulse_mux;
  logic              en_count;
  logic              busy;
  logic              res_valid;
  logic [1:0]        res_ch;
  logic [CNT_W-1:0]  res_count;
  logic              res_timeout;
  logic              scan_done;
`ifdef FREQCHECK_SCAN_OVF_EN
  logic              res_ovf;
`endif

  freqcheck_scan_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .pulse_in(pulse_in), .pulse_mux(pulse_mux), .en_count(en_count),
    .fc_valid(fc_valid), .fc_count(fc_count), .busy(busy), .res_valid(res_valid),
    .res_ch(res_ch), .res_count(res_count), .res_timeout(res_timeout),
    .scan_done(scan_done)
`ifdef FREQCHECK_SCAN_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int cnt;
    bit tmo;
    bit done;
    bit ovf;
    int lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_res = 0;
  int          gate_idx = 0;
  int          start_cyc = 0;
  bit          first_rise = 0;
  bit          cut = 0;
  logic [15:0] vals[NUM_CH];
  int          dly[NUM_CH];
  bit          withhold[NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one scan yields one result per channel in order; a
  // withheld channel times out with count 0; latency is measured from the
  // first cycle after the gate closes.
  task automatic push_scan(input int n_ch);
    exp_t e;
    for (int c = 0; c < n_ch; c++) begin
      e.ch   = c;
      e.tmo  = withhold[c];
      e.cnt  = withhold[c] ? 0 : int'(vals[c]);
      e.done = (c == NUM_CH - 1);
      e.ovf  = !withhold[c] && (vals[c] == 16'hFFFF);
      e.lat  = withhold[c] ? TMO + 1 : dly[c] + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_tables(input int p_withhold);
    for (int c = 0; c < NUM_CH; c++) begin
      vals[c]     = 16'($urandom);
      dly[c]      = $urandom_range(0, 10);
      withhold[c] = ($urandom_range(0, 99) < p_withhold);
    end
  endtask

  task automatic do_start();
    start      = 1'b1;
    start_cyc  = cyc;
    first_rise = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Random asynchronous-looking pulse sources.
  initial forever begin
    @(negedge clk);
    pulse_in = NUM_CH'($urandom);
  end

  // freqcheck stand-in: answers each gate close after dly[ch] cycles with
  // vals[ch], unless the channel is withheld; also drops stray strobes
  // into open gates, which must be ignored.
  initial begin
    bit          prev = 0;
    bit          cur;
    int          pending = -1;
    logic [15:0] pend_val = '0;
    int          c;
    forever begin
      @(negedge clk);
      fc_valid = 1'b0;
      cur = en_count;
      if (pending >= 0) begin
        if (pending == 0) begin
          fc_valid = 1'b1;
          fc_count = pend_val;
        end
        pending--;
      end else if (prev && !cur) begin
        c = gate_idx % NUM_CH;
        gate_idx++;
        if (!withhold[c]) begin
          pend_val = vals[c];
          if (dly[c] == 0) begin
            fc_valid = 1'b1;
            fc_count = pend_val;
          end else begin
            pending = dly[c] - 1;
          end
        end
      end else if (cur && $urandom_range(0, 199) == 0) begin
        fc_valid = 1'b1;
        fc_count = 16'hDEAD;
      end
      prev = cur;
    end
  end

  // Monitor: gate timing plus scoreboard pop on every result.
  initial begin
    bit   prev_en = 0;
    int   run = 0;
    int   last_fall = 0;
    int   last_res = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_en = 0;
        run = 0;
      end else begin
        if (!busy) chk("pulse_mux_idle", 32'(pulse_mux), 32'd0);
        if (en_count && !prev_en) begin
          run = 1;
          if (first_rise) chk("first_gate_latency", 32'(cyc - start_cyc), 32'(1 + SETTLE));
          else            chk("settle_gap", 32'(cyc - last_res), 32'(SETTLE));
          first_rise = 0;
        end else if (en_count) begin
          run++;
        end
        if (!en_count && prev_en) begin
          if (!cut) chk("gate_length", 32'(run), 32'(GATE));
          cut = 0;
          last_fall = cyc;
        end
        prev_en = en_count;
        if (res_valid) begin
          n_res++;
          last_res = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("res_ch", 32'(res_ch), 32'(e.ch));
            chk("res_count", 32'(res_count), 32'(e.cnt));
            chk("res_timeout", 32'(res_timeout), 32'(e.tmo));
            chk("scan_done", 32'(scan_done), 32'(e.done));
            chk("res_latency", 32'(cyc - last_fall), 32'(e.lat));
`ifdef FREQCHECK_SCAN_OVF_EN
            chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
`endif
          end
        end else if (scan_done) begin
          chk("scan_done_alone", 32'd1, 32'd0);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en_count", 32'(en_count), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single scan with fixed counts; a second start mid-scan is ignored.
    rand_tables(0);
    for (int c = 0; c < NUM_CH; c++) vals[c] = 16'((c + 1) * 100);
    push_scan(NUM_CH);
    do_start();
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(20000);

    // Timeout on ch2; ch1 answers on the last allowed wait cycle.
    rand_tables(0);
    withhold[2] = 1;
    dly[1] = TMO - 1;
    push_scan(NUM_CH);
    do_start();
    wait_idle(20000);

    // Continuous: dropped during the second scan, which still completes.
    rand_tables(20);
    push_scan(NUM_CH);
    push_scan(NUM_CH);
    continuous = 1'b1;
    n_res = 0;
    do_start();
    n = 0;
    while (n_res < 6 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("continuous_progress", 32'(n_res >= 6), 32'd1);
    continuous = 1'b0;
    wait_idle(20000);

    // Abort during the ch1 gate: only ch0 reports.
    rand_tables(0);
    push_scan(1);
    gate_idx = 0;
    do_start();
    n = 0;
    while (!(gate_idx >= 1 && en_count) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_ch1_gate", 32'(en_count), 32'd1);
    repeat (100) @(negedge clk);
    cut = 1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_en_count", 32'(en_count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_no_result", 32'(exp_q.size()), 32'd0);
    gate_idx = 0;

    // start together with abort: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_abort_busy", 32'(busy), 32'd0);

    // Restart after abort begins at ch0.
    rand_tables(25);
    push_scan(NUM_CH);
    do_start();
    wait_idle(20000);

    // Asynchronous reset mid-gate clears outputs without a clock edge.
    rand_tables(0);
    gate_idx = 0;
    do_start();
    n = 0;
    while (!en_count && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    cut = 1;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_en_count", 32'(en_count), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_pulse_mux", 32'(pulse_mux), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cut = 0;
    repeat (15) @(negedge clk);
    gate_idx = 0;
    chk("rst_no_result", 32'(exp_q.size()), 32'd0);

    // Saturation boundary values.
    rand_tables(0);
    vals[0] = 16'hFFFF;
    vals[1] = 16'hFFFE;
    vals[2] = 16'h0000;
    push_scan(NUM_CH);
    do_start();
    wait_idle(20000);

    // Fully random scan.
    rand_tables(30);
    push_scan(NUM_CH);
    do_start();
    wait_idle(20000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
